// File: rtl/box_overlay_if.sv
// Box-coordinate handshake from the detection logic (master) into box_overlay (slave).
// Widths follow the overlay's X_BITS/Y_BITS parameters.
interface box_overlay_if #(
   parameter int unsigned X_BITS = 11,
   parameter int unsigned Y_BITS = 10
);
   logic              box_valid;
   logic              box_ready;
   logic              box_en;
   logic [X_BITS-1:0] box_x0;
   logic [X_BITS-1:0] box_x1;
   logic [Y_BITS-1:0] box_y0;
   logic [Y_BITS-1:0] box_y1;

   modport master (
      output box_valid, box_en, box_x0, box_x1, box_y0, box_y1,
      input  box_ready
   );

   modport slave (
      input  box_valid, box_en, box_x0, box_x1, box_y0, box_y1,
      output box_ready
   );
endinterface

// File: rtl/box_overlay.sv
// Two-stage video overlay drawing a bounding-box outline; box updates apply only at frame edges.
// Optional BOX_OVERLAY_CROSSHAIR_EN adds a 1-pixel crosshair through the box centre.
module box_overlay #(
   parameter int unsigned X_BITS  = 11,
   parameter int unsigned Y_BITS  = 10,
   parameter int unsigned THICK   = 2,
   parameter logic [23:0] BOX_RGB = 24'hFF0000
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              vsync_in,
   input  logic              hsync_in,
   input  logic              de_in,
   input  logic [X_BITS-1:0] x_in,
   input  logic [Y_BITS-1:0] y_in,
   input  logic [23:0]       rgb_in,
   box_overlay_if.slave      box_if,
   output logic              vsync_out,
   output logic              hsync_out,
   output logic              de_out,
   output logic [23:0]       rgb_out
);

   localparam logic [X_BITS:0] THICK_X = (X_BITS+1)'(THICK);
   localparam logic [Y_BITS:0] THICK_Y = (Y_BITS+1)'(THICK);

   typedef struct packed {
      logic [X_BITS-1:0] x0;
      logic [X_BITS-1:0] x1;
      logic [Y_BITS-1:0] y0;
      logic [Y_BITS-1:0] y1;
   } box_t;

   logic        pend_vld_q, pend_en_q, act_vld_q, act_en_q;
   box_t        pend_q, act_q;
   logic        vs_s1_q, hs_s1_q, de_s1_q, hit_s1_q;
   logic [23:0] rgb_s1_q;
   logic        vs_s2_q, hs_s2_q, de_s2_q;
   logic [23:0] rgb_s2_q, rgb_d;
   logic        frame_edge, xfer, load_act;
   logic        in_box, on_edge, hit_d;

   assign frame_edge       = vsync_in & ~vs_s1_q;
   assign xfer             = box_if.box_valid & ~pend_vld_q;
   assign load_act         = frame_edge & pend_vld_q;
   assign box_if.box_ready = ~pend_vld_q;

   // xfer needs pend_vld_q low and load_act needs it high, so they never collide.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pend_vld_q <= 1'b0;
         act_vld_q  <= 1'b0;
         act_en_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         if (xfer)
            pend_vld_q <= 1'b1;
         else if (load_act)
            pend_vld_q <= 1'b0;
         if (load_act) begin
            act_vld_q <= 1'b1;
            act_en_q  <= pend_en_q;
         end
      end
   end

   // NOTE: box payload has no reset; it is only ever read while its valid flag is set.
   always_ff @(posedge clk) begin
      if (xfer) begin
         pend_en_q <= box_if.box_en;
         pend_q    <= '{x0: box_if.box_x0, x1: box_if.box_x1,
                        y0: box_if.box_y0, y1: box_if.box_y1};
      end
      if (load_act)
         act_q <= pend_q;
   end

   // Extra top bit keeps x+THICK and x0+THICK from wrapping at the coordinate maximum.
   logic [X_BITS:0] x_e, x0_e, x1_e;
   logic [Y_BITS:0] y_e, y0_e, y1_e;

   assign x_e  = {1'b0, x_in};
   assign x0_e = {1'b0, act_q.x0};
   assign x1_e = {1'b0, act_q.x1};
   assign y_e  = {1'b0, y_in};
   assign y0_e = {1'b0, act_q.y0};
   assign y1_e = {1'b0, act_q.y1};

   assign in_box  = act_vld_q & act_en_q
                  & (x_e >= x0_e) & (x_e <= x1_e)
                  & (y_e >= y0_e) & (y_e <= y1_e);
   assign on_edge = (x_e < x0_e + THICK_X) | (x_e + THICK_X > x1_e)
                  | (y_e < y0_e + THICK_Y) | (y_e + THICK_Y > y1_e);

`ifdef BOX_OVERLAY_CROSSHAIR_EN
   logic [X_BITS-1:0] act_cx_q;
   logic [Y_BITS-1:0] act_cy_q;

   // Centre is taken from the pending box so it becomes valid together with the active box.
   always_ff @(posedge clk) begin
      if (load_act) begin
         act_cx_q <= X_BITS'(({1'b0, pend_q.x0} + {1'b0, pend_q.x1}) >> 1);
         act_cy_q <= Y_BITS'(({1'b0, pend_q.y0} + {1'b0, pend_q.y1}) >> 1);
      end
   end

   assign hit_d = in_box & (on_edge | (x_in == act_cx_q) | (y_in == act_cy_q));
`else
   assign hit_d = in_box & on_edge;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vs_s1_q  <= 1'b0;
         hs_s1_q  <= 1'b0;
         de_s1_q  <= 1'b0;
         hit_s1_q <= 1'b0;
         rgb_s1_q <= '0;
         vs_s2_q  <= 1'b0;
         hs_s2_q  <= 1'b0;
         de_s2_q  <= 1'b0;
         rgb_s2_q <= '0;
      end else begin
         vs_s1_q  <= vsync_in;
         hs_s1_q  <= hsync_in;
         de_s1_q  <= de_in;
         hit_s1_q <= hit_d;
         rgb_s1_q <= rgb_in;
         vs_s2_q  <= vs_s1_q;
         hs_s2_q  <= hs_s1_q;
         de_s2_q  <= de_s1_q;
         rgb_s2_q <= rgb_d;
      end
   end

   always_comb begin
      // NOTE: default first so no path through this block can infer a latch.
      rgb_d = '0;
      if (de_s1_q)
         rgb_d = hit_s1_q ? BOX_RGB : rgb_s1_q;
   end

   assign vsync_out = vs_s2_q;
   assign hsync_out = hs_s2_q;
   assign de_out    = de_s2_q;
   assign rgb_out   = rgb_s2_q;

endmodule

// File: doc/box_overlay.md
# box_overlay

Per-pixel overlay stage that sits directly downstream of the sync generator and ahead of the video transmitter. It consumes the generator's vsync/hsync/data_en and active-area x/y together with the pixel colour fetched for that position. It draws a rectangular bounding-box outline (the current aim target) over the stream. Box coordinates arrive from the detection logic through a valid/ready handshake and take effect only at frame boundaries, so a box never tears mid-frame.

## Interface
- X_BITS, 11, width of x_in and box x coordinates
- Y_BITS, 10, width of y_in and box y coordinates
- THICK, 2, outline thickness in pixels (1..15)
- BOX_RGB, 24'hFF0000, outline colour {R,G,B}
- clk  input  1  pixel clock
- rstn  input  1  asynchronous active-low reset
- vsync_in  input  1  vertical sync from generator, active-high
- hsync_in  input  1  horizontal sync from generator
- de_in  input  1  data enable from generator
- x_in  input  X_BITS  active-area column
- y_in  input  Y_BITS  active-area row
- rgb_in  input  24  source pixel aligned with de_in/x_in/y_in
- box_valid  input  1  new box offered
- box_ready  output  1  block can accept a box
- box_en  input  1  1 = draw offered box, 0 = clear overlay
- box_x0, box_x1  input  X_BITS  left/right column, inclusive
- box_y0, box_y1  input  Y_BITS  top/bottom row, inclusive
- vsync_out, hsync_out, de_out  output  1  sync delayed to match rgb_out
- rgb_out  output  24  overlaid pixel

## Operation
- Two registers: pending (captured box plus pend_vld) and active (box used for drawing plus act_vld/act_en).
- box_ready = !pend_vld. Transfer occurs when box_valid && box_ready. It latches box_en and the coordinates into pending and sets pend_vld.
- Frame edge = vsync_in high while the registered vsync_in was low. On a frame edge with pend_vld=1: active <= pending, pend_vld <= 0. On a frame edge with pend_vld=0: active is unchanged.
- A transfer in the same cycle as a frame edge lands in pending and is applied at the next frame edge.
- Hit test, using the active box: act_en && x0<=x<=x1 && y0<=y<=y1 && (x < x0+THICK || x+THICK > x1 || y < y0+THICK || y+THICK > y1).
- All sums are computed at width+1 bits, so there is no wrap at the coordinate maximum.
- x0>x1 or y0>y1: nothing is drawn (no error).
- A box smaller than 2*THICK is drawn completely filled.
- rgb_out = BOX_RGB when de and hit, else rgb_in. When de is low, rgb_out is 0.

## Timing
- Latency is exactly 2 cycles for vsync, hsync, de and rgb. Stage 1 registers the inputs and the compare results; stage 2 applies the colour mux.
- Sync outputs are pure 2-cycle delays, independent of box state.
- An active-box update at a frame edge (cycle t) affects pixels whose inputs arrive at t+1 onward. Those pixels lie wholly in the next frame's active area.
- Reset values: vsync_out/hsync_out/de_out = 0, rgb_out = 0, box_ready = 1, pend_vld = 0, act_vld = 0, act_en = 0.
- Reset asserted mid-frame discards both the pending and the active box. Output is pass-through after reset until a box is transferred and a frame edge occurs.

## Configuration
- BOX_OVERLAY_CROSSHAIR_EN defined: additionally draws a 1-pixel crosshair of BOX_RGB through the box centre, inside the box bounds only.
  - Centre cx = (x0+x1)>>1 and cy = (y0+y1)>>1, computed at width+1.
  - Crosshair hit = in-box && (x==cx || y==cy).
  - The centre is computed when pending moves to active and is registered with the active box. Latency is unchanged.
- Macro undefined: outline only; no centre logic is synthesised.

## Test plan
- Pass-through: after reset with no box transferred, rgb_in=24'h123456 with de_in=1 -> rgb_out=24'h123456 two cycles later; sync outputs equal the inputs delayed by 2 cycles.
- Outline: transfer box (100,50)-(199,149) with THICK=2, then a frame edge -> next frame (100,50), (101,120), (198,120), (150,148) = FF0000; (102,52) and (150,100) = rgb_in; (99,50) = rgb_in.
- Handshake/deferral: transfer box A mid-frame -> box_ready=0 and the current frame is unchanged. A second offer is held until the frame edge; box_ready returns to 1 the cycle after the edge.
- Clear and degenerate: transfer box_en=0 -> the next frame has no overlay. Transfer x0=300, x1=200 -> no overlay. Transfer a box with x1=2047 (X_BITS=11) -> right edge drawn, no wrap onto column 0.
- Reset mid-frame: assert rstn low during an active line -> all outputs 0 immediately and box_ready=1. After release, pass-through continues until a new box is transferred and a frame edge occurs.
- Crosshair (macro defined): box (0,0)-(100,60) -> (50,10) and (20,30) = FF0000; (20,10) = rgb_in. With the macro undefined, (50,10) = rgb_in.
